// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM state encoding
// and the per-stage write/flush control pair.
package pipe_ctrl_pkg;

    localparam int unsigned STATE_W       = 2;
    localparam int unsigned CNT_W_DEFAULT = 32;

    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        DC_WAIT  = 2'd2
    } PipeCtrlState;

    // Control for one pipeline register; Flush dominates Wr at the register.
    typedef struct packed {
        logic Wr;
        logic Flush;
    } StageCtrl;

    localparam StageCtrl STAGE_RUN    = '{Wr: 1'b1, Flush: 1'b0};
    localparam StageCtrl STAGE_HOLD   = '{Wr: 1'b0, Flush: 1'b0};
    localparam StageCtrl STAGE_BUBBLE = '{Wr: 1'b1, Flush: 1'b1};
    localparam StageCtrl STAGE_RESET  = '{Wr: 1'b0, Flush: 1'b1};

endpackage

// File: rtl/pipe_perf_cnt.sv
// Single wrapping event counter with enable and synchronous active-low clear.
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline stall/flush controller (RUN / DIV_WAIT / DC_WAIT).
// Stall performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             MEM_ExceptValid,
    input  logic             MEM_DcacheBusy,
    input  logic             EX_DivStart,
    input  logic             EX_DivDone,
    input  logic             IF_IcacheBusy,
    input  logic             ID_LoadUse,
    output logic             PC_Wr,
    output logic             ID_Wr,
    output logic             EX_Wr,
    output logic             MEM_Wr,
    output logic             WB_Wr,
    output logic             ID_Flush,
    output logic             EX_Flush,
    output logic             MEM_Flush,
    output logic             WB_Flush,
    output logic             WB_DisWr,
    output logic             EX_DivCancel,
    output logic [CNT_W-1:0] Cnt_Dcache,
    output logic [CNT_W-1:0] Cnt_Div,
    output logic [CNT_W-1:0] Cnt_Icache,
    output logic [CNT_W-1:0] Cnt_LoadUse
);

    PipeCtrlState state_q, state_d;
    logic         div_pend_q, div_pend_d;
    logic         div_done_q, div_done_d;

    logic         pc_wr_c;
    StageCtrl     id_c, ex_c, mem_c, wb_c;
    logic         wb_dis_wr_c;
    logic         div_cancel_c;

    // State and divide-tracking flags
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= RUN;
            div_pend_q <= 1'b0;
            div_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_pend_q <= div_pend_d;
            div_done_q <= div_done_d;
        end
    end

    // Next state and per-cycle pipeline controls, highest-priority event wins
    always_comb begin
        state_d      = state_q;
        div_pend_d   = div_pend_q;
        div_done_d   = div_done_q;
        pc_wr_c      = 1'b1;
        id_c         = STAGE_RUN;
        ex_c         = STAGE_RUN;
        mem_c        = STAGE_RUN;
        wb_c         = STAGE_RUN;
        wb_dis_wr_c  = 1'b0;
        div_cancel_c = 1'b0;

        if (!resetn) begin
            pc_wr_c     = 1'b0;
            id_c        = STAGE_RESET;
            ex_c        = STAGE_RESET;
            mem_c       = STAGE_RESET;
            wb_c        = STAGE_RESET;
            wb_dis_wr_c = 1'b1;
            state_d     = RUN;
            div_pend_d  = 1'b0;
            div_done_d  = 1'b0;
        end else if (MEM_ExceptValid) begin
            // Excepting instruction still reaches WB so CP0 can record it
            id_c         = STAGE_BUBBLE;
            ex_c         = STAGE_BUBBLE;
            mem_c        = STAGE_BUBBLE;
            div_cancel_c = (state_q == DIV_WAIT);
            state_d      = RUN;
            div_pend_d   = 1'b0;
            div_done_d   = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (MEM_DcacheBusy) begin
                        pc_wr_c    = 1'b0;
                        id_c       = STAGE_HOLD;
                        ex_c       = STAGE_HOLD;
                        mem_c      = STAGE_HOLD;
                        wb_c       = STAGE_HOLD;
                        state_d    = DC_WAIT;
                        div_pend_d = EX_DivStart;
                        div_done_d = 1'b0;
                    end else if (EX_DivStart) begin
                        pc_wr_c = 1'b0;
                        id_c    = STAGE_HOLD;
                        ex_c    = STAGE_HOLD;
                        mem_c   = STAGE_BUBBLE;
                        state_d = DIV_WAIT;
                    end else if (ID_LoadUse) begin
                        pc_wr_c = 1'b0;
                        id_c    = STAGE_HOLD;
                        ex_c    = STAGE_BUBBLE;
                    end else if (IF_IcacheBusy) begin
                        pc_wr_c = 1'b0;
                        id_c    = STAGE_BUBBLE;
                    end
                end
                DIV_WAIT: begin
                    if (MEM_DcacheBusy) begin
                        pc_wr_c    = 1'b0;
                        id_c       = STAGE_HOLD;
                        ex_c       = STAGE_HOLD;
                        mem_c      = STAGE_HOLD;
                        wb_c       = STAGE_HOLD;
                        state_d    = DC_WAIT;
                        div_pend_d = 1'b1;
                        div_done_d = EX_DivDone;
                    end else if (!EX_DivDone) begin
                        pc_wr_c = 1'b0;
                        id_c    = STAGE_HOLD;
                        ex_c    = STAGE_HOLD;
                        mem_c   = STAGE_BUBBLE;
                    end else begin
                        state_d = RUN;
                    end
                end
                DC_WAIT: begin
                    // WB instruction already wrote on the entry cycle
                    wb_dis_wr_c = 1'b1;
                    if (MEM_DcacheBusy) begin
                        pc_wr_c    = 1'b0;
                        id_c       = STAGE_HOLD;
                        ex_c       = STAGE_HOLD;
                        mem_c      = STAGE_HOLD;
                        wb_c       = STAGE_HOLD;
                        div_done_d = div_done_q | EX_DivDone;
                    end else begin
                        state_d    = (div_pend_q && !(div_done_q || EX_DivDone))
                                     ? DIV_WAIT : RUN;
                        div_pend_d = 1'b0;
                        div_done_d = 1'b0;
                    end
                end
                default: begin
                    state_d    = RUN;
                    div_pend_d = 1'b0;
                    div_done_d = 1'b0;
                end
            endcase
        end
    end

    assign PC_Wr        = pc_wr_c;
    assign ID_Wr        = id_c.Wr;
    assign EX_Wr        = ex_c.Wr;
    assign MEM_Wr       = mem_c.Wr;
    assign WB_Wr        = wb_c.Wr;
    assign ID_Flush     = id_c.Flush;
    assign EX_Flush     = ex_c.Flush;
    assign MEM_Flush    = mem_c.Flush;
    assign WB_Flush     = wb_c.Flush;
    assign WB_DisWr     = wb_dis_wr_c;
    assign EX_DivCancel = div_cancel_c;

`ifdef PIPE_PERF_CNT_EN
    logic stall_dc_c, stall_div_c, stall_ic_c, stall_lu_c;
    logic run_free_c;

    // Attribute each stalled cycle to its highest-priority cause only
    assign run_free_c  = resetn && !MEM_ExceptValid && !MEM_DcacheBusy;
    assign stall_dc_c  = resetn && !MEM_ExceptValid && MEM_DcacheBusy;
    assign stall_div_c = run_free_c &&
                         (((state_q == RUN) && EX_DivStart) ||
                          ((state_q == DIV_WAIT) && !EX_DivDone));
    assign stall_lu_c  = run_free_c && (state_q == RUN) && !EX_DivStart && ID_LoadUse;
    assign stall_ic_c  = run_free_c && (state_q == RUN) && !EX_DivStart &&
                         !ID_LoadUse && IF_IcacheBusy;

    pipe_perf_cnt #(.W(CNT_W)) u_cnt_dcache (
        .clk(clk), .resetn(resetn), .en_i(stall_dc_c),  .cnt_o(Cnt_Dcache)
    );
    pipe_perf_cnt #(.W(CNT_W)) u_cnt_div (
        .clk(clk), .resetn(resetn), .en_i(stall_div_c), .cnt_o(Cnt_Div)
    );
    pipe_perf_cnt #(.W(CNT_W)) u_cnt_icache (
        .clk(clk), .resetn(resetn), .en_i(stall_ic_c),  .cnt_o(Cnt_Icache)
    );
    pipe_perf_cnt #(.W(CNT_W)) u_cnt_loaduse (
        .clk(clk), .resetn(resetn), .en_i(stall_lu_c),  .cnt_o(Cnt_LoadUse)
    );
`else
    assign Cnt_Dcache  = '0;
    assign Cnt_Div     = '0;
    assign Cnt_Icache  = '0;
    assign Cnt_LoadUse = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipe_ctrl;

    localparam int unsigned CNT_W = 32;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {PC,ID,EX,MEM,WB}_Wr, {ID,EX,MEM,WB}_Flush, WB_DisWr, EX_DivCancel
    localparam logic [10:0] O_DEF     = 11'b11111_0000_0_0;
    localparam logic [10:0] O_RST     = 11'b00000_1111_1_0;
    localparam logic [10:0] O_DIV     = 11'b00011_0010_0_0;
    localparam logic [10:0] O_DC_IN   = 11'b00000_0000_0_0;
    localparam logic [10:0] O_DC_BUSY = 11'b00000_0000_1_0;
    localparam logic [10:0] O_DC_REL  = 11'b11111_0000_1_0;
    localparam logic [10:0] O_EXC     = 11'b11111_1110_0_0;
    localparam logic [10:0] O_EXC_DIV = 11'b11111_1110_0_1;
    localparam logic [10:0] O_IC      = 11'b01111_1000_0_0;
    localparam logic [10:0] O_LU      = 11'b00111_0100_0_0;

    logic clk, resetn;
    logic MEM_ExceptValid, MEM_DcacheBusy, EX_DivStart, EX_DivDone;
    logic IF_IcacheBusy, ID_LoadUse;
    logic PC_Wr, ID_Wr, EX_Wr, MEM_Wr, WB_Wr;
    logic ID_Flush, EX_Flush, MEM_Flush, WB_Flush, WB_DisWr, EX_DivCancel;
    logic [CNT_W-1:0] Cnt_Dcache, Cnt_Div, Cnt_Icache, Cnt_LoadUse;
    logic [10:0] obs;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .MEM_ExceptValid(MEM_ExceptValid), .MEM_DcacheBusy(MEM_DcacheBusy),
        .EX_DivStart(EX_DivStart), .EX_DivDone(EX_DivDone),
        .IF_IcacheBusy(IF_IcacheBusy), .ID_LoadUse(ID_LoadUse),
        .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .EX_Wr(EX_Wr), .MEM_Wr(MEM_Wr), .WB_Wr(WB_Wr),
        .ID_Flush(ID_Flush), .EX_Flush(EX_Flush), .MEM_Flush(MEM_Flush),
        .WB_Flush(WB_Flush), .WB_DisWr(WB_DisWr), .EX_DivCancel(EX_DivCancel),
        .Cnt_Dcache(Cnt_Dcache), .Cnt_Div(Cnt_Div),
        .Cnt_Icache(Cnt_Icache), .Cnt_LoadUse(Cnt_LoadUse)
    );

    assign obs = {PC_Wr, ID_Wr, EX_Wr, MEM_Wr, WB_Wr,
                  ID_Flush, EX_Flush, MEM_Flush, WB_Flush, WB_DisWr, EX_DivCancel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
        return PERF ? CNT_W'(n) : '0;
    endfunction

    task automatic idle_inputs();
        MEM_ExceptValid = 1'b0; MEM_DcacheBusy = 1'b0; EX_DivStart = 1'b0;
        EX_DivDone = 1'b0; IF_IcacheBusy = 1'b0; ID_LoadUse = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #1;
        checks++;
        if (obs !== O_RST) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs, O_RST); end
        @(negedge clk);
        checks++;
        if ({Cnt_Dcache, Cnt_Div, Cnt_Icache, Cnt_LoadUse} !== '0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d/%0d/%0d want 0",
                                Cnt_Dcache, Cnt_Div, Cnt_Icache, Cnt_LoadUse);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (obs !== O_DEF) begin errors++; $display("FAIL run_default: got %b want %b", obs, O_DEF); end
        @(negedge clk);
    endtask

    task automatic test_div();
        apply_reset();
        EX_DivStart = 1'b1;
        #1;
        checks++;
        if (obs !== O_DIV) begin errors++; $display("FAIL div_start: got %b want %b", obs, O_DIV); end
        @(negedge clk);
        EX_DivStart = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            checks++;
            if (obs !== O_DIV) begin errors++; $display("FAIL div_wait c%0d: got %b want %b", i, obs, O_DIV); end
            @(negedge clk);
        end
        EX_DivDone = 1'b1;
        #1;
        checks++;
        if (obs !== O_DEF) begin errors++; $display("FAIL div_done: got %b want %b", obs, O_DEF); end
        @(negedge clk);
        EX_DivDone = 1'b0;
        #1;
        checks++;
        if (obs !== O_DEF) begin errors++; $display("FAIL div_back_to_run: got %b want %b", obs, O_DEF); end
        checks++;
        if (Cnt_Div !== exp_cnt(11)) begin
            errors++; $display("FAIL cnt_div: got %0d want %0d", Cnt_Div, exp_cnt(11));
        end
        @(negedge clk);
    endtask

    task automatic test_dcache();
        logic [10:0] exp_seq [4];
        exp_seq[0] = O_DC_IN; exp_seq[1] = O_DC_BUSY; exp_seq[2] = O_DC_BUSY; exp_seq[3] = O_DC_REL;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            MEM_DcacheBusy = (i < 3);
            #1;
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++; $display("FAIL dcache c%0d: got %b want %b", i, obs, exp_seq[i]);
            end
            @(negedge clk);
        end
        MEM_DcacheBusy = 1'b0;
        #1;
        checks++;
        if (obs !== O_DEF) begin errors++; $display("FAIL dcache_after: got %b want %b", obs, O_DEF); end
        checks++;
        if (Cnt_Dcache !== exp_cnt(3)) begin
            errors++; $display("FAIL cnt_dcache: got %0d want %0d", Cnt_Dcache, exp_cnt(3));
        end
        @(negedge clk);
    endtask

    task automatic test_except_div();
        apply_reset();
        EX_DivStart = 1'b1;
        @(negedge clk);
        EX_DivStart = 1'b0;
        repeat (3) @(negedge clk);
        MEM_ExceptValid = 1'b1;
        #1;
        checks++;
        if (obs !== O_EXC_DIV) begin errors++; $display("FAIL except_in_div: got %b want %b", obs, O_EXC_DIV); end
        @(negedge clk);
        MEM_ExceptValid = 1'b0;
        #1;
        checks++;
        if (obs !== O_DEF) begin errors++; $display("FAIL except_div_next: got %b want %b", obs, O_DEF); end
        checks++;
        if (Cnt_Div !== exp_cnt(4)) begin
            errors++; $display("FAIL cnt_div_except: got %0d want %0d", Cnt_Div, exp_cnt(4));
        end
        @(negedge clk);
        // Exception outranks a busy dcache in RUN
        MEM_ExceptValid = 1'b1; MEM_DcacheBusy = 1'b1;
        #1;
        checks++;
        if (obs !== O_EXC) begin errors++; $display("FAIL except_over_dcache: got %b want %b", obs, O_EXC); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (obs !== O_DEF) begin errors++; $display("FAIL except_dc_next: got %b want %b", obs, O_DEF); end
        @(negedge clk);
    endtask

    task automatic test_dc_div();
        // Divide pending on DC_WAIT entry resumes in DIV_WAIT
        apply_reset();
        MEM_DcacheBusy = 1'b1; EX_DivStart = 1'b1;
        #1;
        checks++;
        if (obs !== O_DC_IN) begin errors++; $display("FAIL dcdiv_entry: got %b want %b", obs, O_DC_IN); end
        @(negedge clk);
        EX_DivStart = 1'b0;
        #1;
        checks++;
        if (obs !== O_DC_BUSY) begin errors++; $display("FAIL dcdiv_busy: got %b want %b", obs, O_DC_BUSY); end
        @(negedge clk);
        MEM_DcacheBusy = 1'b0;
        #1;
        checks++;
        if (obs !== O_DC_REL) begin errors++; $display("FAIL dcdiv_release: got %b want %b", obs, O_DC_REL); end
        @(negedge clk);
        #1;
        checks++;
        if (obs !== O_DIV) begin errors++; $display("FAIL dcdiv_resume_div: got %b want %b", obs, O_DIV); end
        @(negedge clk);
        EX_DivDone = 1'b1;
        #1;
        checks++;
        if (obs !== O_DEF) begin errors++; $display("FAIL dcdiv_done: got %b want %b", obs, O_DEF); end
        @(negedge clk);
        // Done latched during DC_WAIT returns straight to RUN
        apply_reset();
        MEM_DcacheBusy = 1'b1; EX_DivStart = 1'b1;
        @(negedge clk);
        EX_DivStart = 1'b0; EX_DivDone = 1'b1;
        #1;
        checks++;
        if (obs !== O_DC_BUSY) begin errors++; $display("FAIL dcdone_busy: got %b want %b", obs, O_DC_BUSY); end
        @(negedge clk);
        MEM_DcacheBusy = 1'b0; EX_DivDone = 1'b0;
        #1;
        checks++;
        if (obs !== O_DC_REL) begin errors++; $display("FAIL dcdone_release: got %b want %b", obs, O_DC_REL); end
        @(negedge clk);
        #1;
        checks++;
        if (obs !== O_DEF) begin errors++; $display("FAIL dcdone_run: got %b want %b", obs, O_DEF); end
        checks++;
        if ({Cnt_Dcache, Cnt_Div} !== {exp_cnt(2), exp_cnt(0)}) begin
            errors++; $display("FAIL cnt_dcdone: got dc=%0d div=%0d want dc=%0d div=%0d",
                                Cnt_Dcache, Cnt_Div, exp_cnt(2), exp_cnt(0));
        end
        @(negedge clk);
    endtask

    task automatic test_ic_lu();
        apply_reset();
        IF_IcacheBusy = 1'b1; ID_LoadUse = 1'b1;
        #1;
        checks++;
        if (obs !== O_LU) begin errors++; $display("FAIL ic_lu_both: got %b want %b", obs, O_LU); end
        @(negedge clk);
        ID_LoadUse = 1'b0;
        #1;
        checks++;
        if ({Cnt_LoadUse, Cnt_Icache} !== {exp_cnt(1), exp_cnt(0)}) begin
            errors++; $display("FAIL cnt_ic_lu: got lu=%0d ic=%0d want lu=%0d ic=%0d",
                                Cnt_LoadUse, Cnt_Icache, exp_cnt(1), exp_cnt(0));
        end
        checks++;
        if (obs !== O_IC) begin errors++; $display("FAIL icache_only: got %b want %b", obs, O_IC); end
        @(negedge clk);
        IF_IcacheBusy = 1'b0; ID_LoadUse = 1'b1;
        #1;
        checks++;
        if (obs !== O_LU) begin errors++; $display("FAIL loaduse_only: got %b want %b", obs, O_LU); end
        @(negedge clk);
        ID_LoadUse = 1'b0;
        #1;
        checks++;
        if ({Cnt_LoadUse, Cnt_Icache} !== {exp_cnt(2), exp_cnt(1)}) begin
            errors++; $display("FAIL cnt_ic_lu2: got lu=%0d ic=%0d want lu=%0d ic=%0d",
                                Cnt_LoadUse, Cnt_Icache, exp_cnt(2), exp_cnt(1));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        MEM_DcacheBusy = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (obs !== O_RST) begin errors++; $display("FAIL reset_in_dc: got %b want %b", obs, O_RST); end
        @(negedge clk);
        resetn = 1'b1; MEM_DcacheBusy = 1'b0;
        #1;
        checks++;
        if (obs !== O_DEF) begin errors++; $display("FAIL reset_dc_run: got %b want %b", obs, O_DEF); end
        checks++;
        if (Cnt_Dcache !== '0) begin errors++; $display("FAIL reset_dc_cnt: got %0d want 0", Cnt_Dcache); end
        @(negedge clk);
        // Reset mid-divide must not pulse EX_DivCancel
        EX_DivStart = 1'b1;
        @(negedge clk);
        EX_DivStart = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (obs !== O_RST) begin errors++; $display("FAIL reset_in_div: got %b want %b", obs, O_RST); end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (obs !== O_DEF) begin errors++; $display("FAIL reset_div_run: got %b want %b", obs, O_DEF); end
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_div();
        test_dcache();
        test_except_div();
        test_dc_div();
        test_ic_lu();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
